// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
package mult_div_unit_pkg;
  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/command and HI/LO result bundle between control path and mult/div unit.
interface mult_div_unit_if import mult_div_unit_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OperandA;
  logic [WIDTH-1:0] OperandB;
  logic             WriteHi;
  logic             WriteLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, OperandA, OperandB, WriteHi, WriteLo,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, WriteHi, WriteLo,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one shift-add or
// restoring shift-subtract step per cycle through a single shared adder.
module mult_div_unit import mult_div_unit_pkg::*; #(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     araw_q, araw_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       add_x, add_y, sum;
  logic                 sa, sb;
  logic [WIDTH-1:0]     amag, bmag;
  logic [WIDTH:0]       step;
  logic [2*WIDTH-1:0]   prod, prod_s;

  // Divide: x = remainder shifted left with next dividend bit, sum = x - divisor.
  // Multiply: x = upper partial product, sum = x + multiplicand.
  assign add_x = is_div_q ? {acc_q[WIDTH-1:0], mq_q[WIDTH-1]} : acc_q;
  assign add_y = {1'b0, b_q};
  assign sum   = add_x + (is_div_q ? ~add_y : add_y) + {{WIDTH{1'b0}}, is_div_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    b_d      = b_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    sa       = 1'b0;
    sb       = 1'b0;
    amag     = bus.OperandA;
    bmag     = bus.OperandB;
    step     = acc_q;
    prod     = {acc_q[WIDTH-1:0], mq_q};
    prod_s   = prod;

    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          sa       = ~bus.Op[0] & bus.OperandA[WIDTH-1];
          sb       = ~bus.Op[0] & bus.OperandB[WIDTH-1];
          amag     = sa ? -bus.OperandA : bus.OperandA;
          bmag     = sb ? -bus.OperandB : bus.OperandB;
          is_div_d = bus.Op[1];
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          dz_d     = bus.Op[1] & (bus.OperandB == '0);
          araw_d   = bus.OperandA;
          acc_d    = '0;
          mq_d     = amag;
          b_d      = bmag;
          cnt_d    = '0;
          state_d  = RUN;
        end else begin
          if (bus.WriteHi) hi_d = bus.OperandA;
          if (bus.WriteLo) lo_d = bus.OperandA;
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = sum[WIDTH] ? add_x : sum;
          mq_d  = {mq_q[WIDTH-2:0], ~sum[WIDTH]};
        end else begin
          step  = mq_q[0] ? sum : acc_q;
          acc_d = {1'b0, step[WIDTH:1]};
          mq_d  = {step[0], mq_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (dz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo_d = neg_q ? -mq_q : mq_q;
          end
        end else begin
          prod_s = neg_q ? -prod : prod;
          hi_d   = prod_s[2*WIDTH-1:WIDTH];
          lo_d   = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      b_q      <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      b_q      <= b_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, busy window,
// ignored commands while busy, MTHI/MTLO and mid-operation reset.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at the current time (#1 after an edge) and wait for Done.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int unsigned n = 0;
    int unsigned busy_cnt = 0;
    bit got_done = 0;
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    if (bus.Busy) busy_cnt++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.Done) begin
        got_done = 1;
        break;
      end
      if (bus.Busy) busy_cnt++;
    end
    chk({tag, " done"}, 64'(got_done), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({tag, " busy_at_done"}, 64'(bus.Busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.Hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(bus.Lo), 64'(exp_lo));
  endtask

  initial begin
    logic [31:0] lo_before;
    bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset hi", 64'(bus.Hi), 64'd0);
    chk("reset lo", 64'(bus.Lo), 64'd0);
    chk("reset busy", 64'(bus.Busy), 64'd0);
    chk("reset done", 64'(bus.Done), 64'd0);

    // Back-to-back: each run_op issues Start in the cycle Done is high.
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_zero", OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_op("div_zero",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Commands while busy must be ignored; Hi/Lo hold during RUN.
    lo_before = bus.Lo;
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd6; bus.OperandB = 32'd7;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.Start = 1'b1; bus.Op = OP_DIVU; bus.OperandA = 32'd9; bus.OperandB = 32'd3;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    bus.WriteHi = 1'b1; bus.OperandA = 32'h0000DEAD;
    @(posedge clk); #1;
    bus.WriteHi = 1'b0;
    chk("run hold lo", 64'(bus.Lo), 64'(lo_before));
    chk("run hold hi", 64'(bus.Hi), 64'd0);
    begin
      bit got_done = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (bus.Done) begin got_done = 1; break; end
      end
      chk("busy_ign done", 64'(got_done), 64'd1);
    end
    chk("busy_ign hi", 64'(bus.Hi), 64'd0);
    chk("busy_ign lo", 64'(bus.Lo), 64'd42);
    @(posedge clk); #1;
    chk("busy_ign no_restart", 64'(bus.Busy), 64'd0);

    // MTHI+MTLO together, then MTLO alone.
    bus.WriteHi = 1'b1; bus.WriteLo = 1'b1; bus.OperandA = 32'h5555AAAA;
    @(posedge clk); #1;
    bus.WriteHi = 1'b0; bus.WriteLo = 1'b0;
    chk("mthilo hi", 64'(bus.Hi), 64'h5555AAAA);
    chk("mthilo lo", 64'(bus.Lo), 64'h5555AAAA);
    chk("mthilo done", 64'(bus.Done), 64'd0);
    bus.WriteLo = 1'b1; bus.OperandA = 32'h00001234;
    @(posedge clk); #1;
    bus.WriteLo = 1'b0;
    chk("mtlo lo", 64'(bus.Lo), 64'h1234);
    chk("mtlo hi", 64'(bus.Hi), 64'h5555AAAA);
    chk("mtlo done", 64'(bus.Done), 64'd0);

    // Start with a write in the same idle cycle: write dropped.
    bus.Start = 1'b1; bus.Op = OP_MULTU; bus.OperandA = 32'd6; bus.OperandB = 32'd7;
    bus.WriteHi = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.WriteHi = 1'b0;
    chk("start_wr hi", 64'(bus.Hi), 64'h5555AAAA);
    chk("start_wr busy", 64'(bus.Busy), 64'd1);

    // Reset sampled at the 10th RUN edge discards the op.
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid busy", 64'(bus.Busy), 64'd0);
    chk("rst_mid done", 64'(bus.Done), 64'd0);
    chk("rst_mid hi", 64'(bus.Hi), 64'd0);
    chk("rst_mid lo", 64'(bus.Lo), 64'd0);
    run_op("after_rst", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
